register_write_arbiter: RTL and testbench
=========================================

# register_write_arbiter

Shares the single write port of the general-purpose register file between the in-order pipeline writeback stage and a long-latency functional unit (multiply/divide) that completes out of band. Long-latency results are buffered in a small queue and normally drained into idle writeback cycles; a starvation limit forces a drain by stalling the pipeline writeback. A per-register scoreboard tracks destinations of issued long-latency ops so decode can stall on read-after-write hazards.

## Interface
- QUEUE_DEPTH, 2: long-latency result queue entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty queue may lose to pipeline writeback before it is forced through; ≥1.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wbValid  in  1  pipeline writeback request this cycle.
- wbId  in  register_id_t  pipeline destination register.
- wbData  in  int_t  pipeline write data.
- wbProgramCounter  in  int_t  PC of the writing instruction.
- wbStall  out  1  pipeline must hold its writeback; wbValid/wbId/wbData are re-presented next cycle.
- luIssue  in  1  long-latency op accepted for execution this cycle.
- luIssueId  in  register_id_t  its destination register.
- luValid  in  1  long-latency result offered.
- luReady  out  1  queue accepts the result; transfer when luValid && luReady.
- luId, luData, luProgramCounter  in  register_id_t / int_t / int_t  result payload.
- readId  in  register_read_id_t  decode-stage read ids.
- readHazard  out  1  a nonzero read id has a pending long-latency write.
- writeId  out  register_id_t  to register file.
- writeEnabled  out  1  to register file.
- dataWrite  out  int_t  to register file.
- programCounterWrite  out  int_t  to register file.

## Operation
- Queue: FIFO of write_request_t {id, data, programCounter}; enqueue on luValid && luReady; dequeue when queue wins the port. luReady = !full (no same-cycle bypass when full). Simultaneous enqueue and dequeue permitted when not full; count unchanged.
- Arbitration each cycle, combinational:
  - queue empty: pipeline wins if wbValid.
  - queue non-empty, !wbValid: queue wins.
  - queue non-empty, wbValid, starveCount < STARVE_LIMIT: pipeline wins, starveCount += 1.
  - queue non-empty, wbValid, starveCount == STARVE_LIMIT: queue wins, wbStall = 1.
  - starveCount cleared whenever queue wins or queue is empty; never exceeds STARVE_LIMIT.
- Write port: writeEnabled = 1 iff a winner exists; writeId/dataWrite/programCounterWrite from the winner, else zero. Id 0 passed through unchanged (register file discards).
- Scoreboard: 2-bit pending count per register 1..31. luIssue with nonzero id: +1. Queue winning with nonzero id: −1 for that id. Both on same id same cycle: unchanged. Issue at count 3 is illegal (simulation assertion; count saturates). Register 0 never pending.
- readHazard = (id1≠0 && pending[id1]≠0) || (id2≠0 && pending[id2]≠0); combinational, reflects state at cycle start (a write draining this cycle still flags hazard).
- Debug: on each grant, $display "WA: <pipe|queue> @0x<pc>: r<id> <= 0x<data>".

## Timing
- Pipeline writeback: zero latency, same cycle as wbValid (register file captures on negedge).
- Long-latency result: earliest write is the cycle after acceptance; no same-cycle bypass.
- Pending count drops on the posedge ending the write cycle; readHazard clears the following cycle.
- Reset (any time, including with queue occupied): queue emptied, all pending counts 0, starveCount 0; during reset writeEnabled=0, wbStall=0, luReady=0, readHazard=0; luReady=1 from first cycle after reset. Long-latency unit is reset by the same signal; in-flight results are lost.
- Worst-case pipeline stall: one cycle per STARVE_LIMIT+1 cycles while queue non-empty.

## Structure
- Shared package: int_t, register_id_t, register_read_id_t (existing), new write_request_t.
- Sub-module write_request_queue: parameterised FIFO (QUEUE_DEPTH, write_request_t), with full/empty, wrap-around pointers plus occupancy count.

## Test plan
- Idle queue, wbValid with r8 <= 0x12345678 -> writeEnabled same cycle, writeId=8, no stall.
- luIssue r5, decode reads r5 -> readHazard=1; luValid r5=0xDEADBEEF with wbValid=0 -> written next cycle, readHazard=0 cycle after.
- Queue holds one entry, wbValid every cycle, STARVE_LIMIT=4 -> pipeline wins 4 cycles, cycle 5 queue wins with wbStall=1, starveCount returns to 0.
- Offer 3 results back-to-back, wbValid held high -> luReady drops after 2 accepts, third accepted after first drain; FIFO order preserved.
- Two luIssue to r9, one drain -> readHazard still 1; second drain -> 0; same-cycle issue+drain on r9 leaves count unchanged.
- Reset asserted with 2 queued entries and pending r3 -> next cycle writeEnabled=0, readHazard=0 for r3, luReady=1.

Source files
------------

// File: rtl/register_write_arbiter_pkg.sv
// rtl/register_write_arbiter_pkg.sv - shared types for the register write port arbiter
package register_write_arbiter_pkg;

    typedef logic [31:0] int_t;
    typedef logic [4:0] register_id_t;
    typedef register_id_t [1:0] register_read_id_t;

    typedef struct packed {
        register_id_t id;
        int_t         data;
        int_t         programCounter;
    } write_request_t;

    typedef enum logic [1:0] {
        GrantNone,
        GrantPipe,
        GrantQueue
    } grant_t;

    typedef logic [1:0] pending_count_t;

    localparam int RegisterCount = 32;

endpackage

// File: rtl/register_write_arbiter_queue.sv
// rtl/register_write_arbiter_queue.sv - FIFO buffering long-latency write requests
import register_write_arbiter_pkg::*;

module write_request_queue #(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           pushValid,
    input  write_request_t pushRequest,
    input  logic           popValid,
    output write_request_t headRequest,
    output logic           full,
    output logic           empty
);
    localparam int PtrWidth = $clog2(QUEUE_DEPTH);

    write_request_t          entries [QUEUE_DEPTH];
    logic [PtrWidth-1:0]     readPointer;
    logic [PtrWidth-1:0]     writePointer;
    logic [PtrWidth:0]       count;
    logic                    doPush;
    logic                    doPop;

    assign full        = count == (PtrWidth + 1)'(QUEUE_DEPTH);
    assign empty       = count == '0;
    assign doPush      = pushValid && !full;
    assign doPop       = popValid && !empty;
    assign headRequest = entries[readPointer];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            readPointer  <= '0;
            writePointer <= '0;
            count        <= '0;
        end else begin
            if (doPush) writePointer <= writePointer + PtrWidth'(1);
            if (doPop)  readPointer  <= readPointer + PtrWidth'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (PtrWidth + 1)'(1);
                2'b01:   count <= count - (PtrWidth + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) entries[writePointer] <= pushRequest;
    end

endmodule

// File: rtl/register_write_arbiter.sv
// rtl/register_write_arbiter.sv - shares the register file write port between writeback and long-latency results
import register_write_arbiter_pkg::*;

module register_write_arbiter #(
    parameter int QUEUE_DEPTH  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wbValid,
    input  register_id_t      wbId,
    input  int_t              wbData,
    input  int_t              wbProgramCounter,
    output logic              wbStall,
    input  logic              luIssue,
    input  register_id_t      luIssueId,
    input  logic              luValid,
    output logic              luReady,
    input  register_id_t      luId,
    input  int_t              luData,
    input  int_t              luProgramCounter,
    input  register_read_id_t readId,
    output logic              readHazard,
    output register_id_t      writeId,
    output logic              writeEnabled,
    output int_t              dataWrite,
    output int_t              programCounterWrite
);
    localparam int StarveWidth = $clog2(STARVE_LIMIT + 1);

    write_request_t           headRequest;
    logic                     queueFull;
    logic                     queueEmpty;
    grant_t                   grant;
    logic [StarveWidth-1:0]   starveCount;
    logic [StarveWidth-1:0]   starveNext;
    pending_count_t           pending [RegisterCount];
    logic [RegisterCount-1:0] issueMask;
    logic [RegisterCount-1:0] drainMask;

    assign luReady = !reset && !queueFull;

    write_request_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) queue (
        .clock       (clock),
        .reset       (reset),
        .pushValid   (luValid && luReady),
        .pushRequest ('{id: luId, data: luData, programCounter: luProgramCounter}),
        .popValid    (grant == GrantQueue),
        .headRequest (headRequest),
        .full        (queueFull),
        .empty       (queueEmpty)
    );

    // The queue only loses to writeback STARVE_LIMIT times in a row before it forces a stall.
    always_comb begin
        grant      = GrantNone;
        wbStall    = 1'b0;
        starveNext = '0;
        if (reset) begin
            grant = GrantNone;
        end else if (queueEmpty) begin
            if (wbValid) grant = GrantPipe;
        end else if (!wbValid) begin
            grant = GrantQueue;
        end else if (starveCount < StarveWidth'(STARVE_LIMIT)) begin
            grant      = GrantPipe;
            starveNext = starveCount + StarveWidth'(1);
        end else begin
            grant   = GrantQueue;
            wbStall = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) starveCount <= '0;
        else       starveCount <= starveNext;
    end

    always_comb begin
        writeEnabled        = 1'b0;
        writeId             = '0;
        dataWrite           = '0;
        programCounterWrite = '0;
        case (grant)
            GrantPipe: begin
                writeEnabled        = 1'b1;
                writeId             = wbId;
                dataWrite           = wbData;
                programCounterWrite = wbProgramCounter;
            end
            GrantQueue: begin
                writeEnabled        = 1'b1;
                writeId             = headRequest.id;
                dataWrite           = headRequest.data;
                programCounterWrite = headRequest.programCounter;
            end
            default: writeEnabled = 1'b0;
        endcase
    end

    always_comb begin
        issueMask = '0;
        drainMask = '0;
        if (luIssue) issueMask[luIssueId] = 1'b1;
        if (grant == GrantQueue) drainMask[headRequest.id] = 1'b1;
        issueMask[0] = 1'b0;
        drainMask[0] = 1'b0;
    end

    // Issue and drain on the same register in one cycle cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RegisterCount; i++) pending[i] <= '0;
        end else begin
            for (int i = 1; i < RegisterCount; i++) begin
                if (issueMask[i] && !drainMask[i] && pending[i] != 2'd3)
                    pending[i] <= pending[i] + 2'd1;
                else if (drainMask[i] && !issueMask[i] && pending[i] != 2'd0)
                    pending[i] <= pending[i] - 2'd1;
            end
        end
    end

    assign readHazard = !reset &&
        ((readId[0] != '0 && pending[readId[0]] != 2'd0) ||
         (readId[1] != '0 && pending[readId[1]] != 2'd0));

    pendingOverflow: assert property (@(posedge clock) disable iff (reset)
        !(issueMask[luIssueId] && !drainMask[luIssueId] && pending[luIssueId] == 2'd3));

endmodule

// File: tb/tb_register_write_arbiter.sv
// tb/tb_register_write_arbiter.sv - randomized scoreboard bench for register_write_arbiter
module tb_register_write_arbiter;
    import register_write_arbiter_pkg::*;

    localparam int QD = 2;
    localparam int SL = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              wbValid;
    register_id_t      wbId;
    int_t              wbData;
    int_t              wbProgramCounter;
    logic              wbStall;
    logic              luIssue;
    register_id_t      luIssueId;
    logic              luValid;
    logic              luReady;
    register_id_t      luId;
    int_t              luData;
    int_t              luProgramCounter;
    register_read_id_t readId;
    logic              readHazard;
    register_id_t      writeId;
    logic              writeEnabled;
    int_t              dataWrite;
    int_t              programCounterWrite;

    always #5 clock = ~clock;

    register_write_arbiter #(
        .QUEUE_DEPTH  (QD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .wbValid             (wbValid),
        .wbId                (wbId),
        .wbData              (wbData),
        .wbProgramCounter    (wbProgramCounter),
        .wbStall             (wbStall),
        .luIssue             (luIssue),
        .luIssueId           (luIssueId),
        .luValid             (luValid),
        .luReady             (luReady),
        .luId                (luId),
        .luData              (luData),
        .luProgramCounter    (luProgramCounter),
        .readId              (readId),
        .readHazard          (readHazard),
        .writeId             (writeId),
        .writeEnabled        (writeEnabled),
        .dataWrite           (dataWrite),
        .programCounterWrite (programCounterWrite)
    );

    typedef struct packed {
        logic         we;
        register_id_t id;
        int_t         data;
        int_t         pc;
        logic         stall;
        logic         ready;
        logic         hazard;
    } expect_t;

    expect_t        expQ[$];
    write_request_t modelQ[$];
    register_id_t   inflight[$];
    int             pend[32];
    int             starve;
    logic           holdWb;
    logic           luOffer;
    write_request_t luReq;
    int             tests = 0;
    int             failures = 0;
    expect_t        expectedRec;
    expect_t        actualRec;

    function automatic register_id_t pickRead();
        if (inflight.size() > 0 && $urandom_range(1) == 1)
            return inflight[$urandom_range(inflight.size() - 1)];
        return 5'($urandom_range(31));
    endfunction

    task automatic clearModel();
        modelQ.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        starve  = 0;
        luOffer = 1'b0;
        holdWb  = 1'b0;
    endtask

    task automatic cycle(input bit rst, input int wbPct, input int luPct, input int issPct);
        expect_t        e;
        write_request_t head;
        bit             qEmpty;
        bit             grantPipe;
        bit             grantQueue;
        @(posedge clock);
        #1;
        reset = rst;
        if (!holdWb) begin
            wbValid          = ($urandom_range(99) < wbPct);
            wbId             = 5'($urandom_range(31));
            wbData           = $urandom;
            wbProgramCounter = $urandom;
        end
        if (!luOffer && inflight.size() > 0 && $urandom_range(99) < luPct) begin
            luOffer             = 1'b1;
            luReq.id            = inflight[0];
            luReq.data          = $urandom;
            luReq.programCounter = $urandom;
        end
        luValid          = luOffer;
        luId             = luReq.id;
        luData           = luReq.data;
        luProgramCounter = luReq.programCounter;
        luIssueId        = 5'($urandom_range(31));
        luIssue          = ($urandom_range(99) < issPct) && pend[luIssueId] < 3 && inflight.size() < 8;
        readId[0]        = pickRead();
        readId[1]        = pickRead();

        e = '0;
        if (rst) begin
            clearModel();
        end else begin
            e.ready  = modelQ.size() < QD;
            e.hazard = (readId[0] != 0 && pend[readId[0]] != 0) ||
                       (readId[1] != 0 && pend[readId[1]] != 0);
            qEmpty     = modelQ.size() == 0;
            grantPipe  = wbValid && (qEmpty || starve < SL);
            grantQueue = !qEmpty && !grantPipe;
            e.stall    = grantQueue && wbValid;
            if (grantPipe) begin
                e.we = 1'b1; e.id = wbId; e.data = wbData; e.pc = wbProgramCounter;
            end
            if (grantQueue) begin
                head = modelQ.pop_front();
                e.we = 1'b1; e.id = head.id; e.data = head.data; e.pc = head.programCounter;
                if (head.id != 0 && pend[head.id] > 0) pend[head.id]--;
            end
            starve = (grantPipe && !qEmpty) ? starve + 1 : 0;
            if (luIssue && luIssueId != 0) pend[luIssueId]++;
            if (luOffer && e.ready) begin
                modelQ.push_back(luReq);
                void'(inflight.pop_front());
                luOffer = 1'b0;
            end
            if (luIssue) inflight.push_back(luIssueId);
            holdWb = e.stall;
        end
        expQ.push_back(e);
    endtask

    initial forever begin
        @(negedge clock);
        if (expQ.size() > 0) begin
            expectedRec = expQ.pop_front();
            actualRec   = {writeEnabled, writeId, dataWrite, programCounterWrite, wbStall, luReady, readHazard};
            tests++;
            if (actualRec !== expectedRec) begin
                failures++;
                $display("FAIL port_check t=%0t got we=%b id=%0d data=%h pc=%h stall=%b ready=%b hazard=%b required we=%b id=%0d data=%h pc=%h stall=%b ready=%b hazard=%b",
                         $time, actualRec.we, actualRec.id, actualRec.data, actualRec.pc,
                         actualRec.stall, actualRec.ready, actualRec.hazard,
                         expectedRec.we, expectedRec.id, expectedRec.data, expectedRec.pc,
                         expectedRec.stall, expectedRec.ready, expectedRec.hazard);
            end
        end
    end

    initial begin
        reset = 1'b1; wbValid = 1'b0; wbId = '0; wbData = '0; wbProgramCounter = '0;
        luIssue = 1'b0; luIssueId = '0; luValid = 1'b0; luId = '0; luData = '0;
        luProgramCounter = '0; readId = '0; luReq = '0;
        clearModel();
        repeat (3) cycle(1'b1, 50, 50, 30);
        for (int i = 0; i < 1500; i++) cycle($urandom_range(199) == 0, 50, 60, 30);
        for (int i = 0; i < 1500; i++) cycle($urandom_range(299) == 0, 95, 80, 40);
        for (int i = 0; i < 1000; i++) cycle($urandom_range(199) == 0, 10, 90, 50);
        @(negedge clock);
        #1;
        tests++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain_check got %0d unchecked cycles, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
